// File: rtl/entropy_pkg.sv
// Shared types and constants for the entropy pool scheduler and its arbiter.
package entropy_pkg;

  localparam int ENTROPY_WORD_WIDTH = 32;

  typedef enum logic [1:0] {
    STARTUP,
    RUN,
    FAULT
  } pool_state_t;

endpackage

// File: rtl/entropy_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, registered last-grant pointer.
module entropy_rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               enable_i,
  input  logic               advance_i,
  output logic [NUM_REQ-1:0] grant_o
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PW-1:0] last_q;
  logic [PW-1:0] winner;

  // Scan from lowest priority to highest so the last hit (just after last_q) wins.
  always_comb begin
    int idx;
    idx     = 0;
    grant_o = '0;
    winner  = last_q;
    if (enable_i) begin
      for (int k = NUM_REQ; k >= 1; k--) begin
        idx = (int'(last_q) + k) % NUM_REQ;
        if (req_i[idx]) begin
          grant_o      = '0;
          grant_o[idx] = 1'b1;
          winner       = PW'(idx);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= PW'(NUM_REQ - 1);
    end else if (advance_i) begin
      last_q <= winner;
    end
  end

endmodule

// File: rtl/entropy_pool_scheduler.sv
// Health-tests jitter words, buffers passing words in a FIFO and hands them
// out one per cycle to round-robin arbitrated requesters.
module entropy_pool_scheduler
  import entropy_pkg::*;
#(
  parameter int NUM_REQ       = 2,
  parameter int FIFO_DEPTH    = 4,
  parameter int STARTUP_WORDS = 16,
  parameter int REP_LIMIT     = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [ENTROPY_WORD_WIDTH-1:0] entropy_word,
  input  logic                          entropy_valid,
  input  logic [NUM_REQ-1:0]            req,
  output logic [NUM_REQ-1:0]            grant,
  output logic [ENTROPY_WORD_WIDTH-1:0] rd_data,
  output logic                          rd_valid,
  output logic                          fault,
  input  logic                          fault_clear,
  output logic                          ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [7:0]                    drop_count
);

  localparam int AW = $clog2(FIFO_DEPTH);

  pool_state_t state_q, state_d;

  logic [ENTROPY_WORD_WIDTH-1:0] prev_word_q;
  logic                          prev_valid_q;
  logic [3:0]                    rep_cnt_q;
  logic [7:0]                    startup_cnt_q;

  logic [ENTROPY_WORD_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]                 wr_ptr_q, rd_ptr_q;
  logic [AW:0]                   count_q;

  logic [NUM_REQ-1:0]            grant_q, grant_d, arb_grant;
  logic [ENTROPY_WORD_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                          rd_valid_q, fault_q, fault_d, ready_q, ready_d;
  logic [7:0]                    drop_q;

  logic       word_ok, rep_match, rep_fail, pass, startup_done, enter_fault;
  logic [3:0] rep_next;
  logic       fifo_empty, fifo_full, arb_enable, pop, push, drop;

  assign word_ok      = entropy_valid && (state_q != FAULT);
  assign rep_match    = prev_valid_q && (entropy_word == prev_word_q);
  assign rep_next     = rep_match ? (rep_cnt_q + 4'd1) : 4'd1;
  assign rep_fail     = word_ok && (rep_next >= 4'(REP_LIMIT));
  assign pass         = word_ok && !rep_fail;
  assign startup_done = pass && (state_q == STARTUP) &&
                        ((startup_cnt_q + 8'd1) == 8'(STARTUP_WORDS));

  assign fifo_empty  = (count_q == '0);
  assign fifo_full   = (count_q == (AW+1)'(FIFO_DEPTH));
  assign arb_enable  = (state_q == RUN) && !fifo_empty;
  assign enter_fault = (state_q != FAULT) && (state_d == FAULT);
  // A grant arbitrated in the same cycle as a health failure is discarded with the flush.
  assign pop         = (|arb_grant) && !enter_fault;
  assign push        = pass && (state_q == RUN) && (!fifo_full || pop);
  assign drop        = pass && (state_q == RUN) && fifo_full && !pop;

  entropy_rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_arbiter (
    .clk      (clk),
    .rst      (rst),
    .req_i    (req),
    .enable_i (arb_enable),
    .advance_i(pop),
    .grant_o  (arb_grant)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= STARTUP;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      STARTUP: begin
        if (rep_fail)          state_d = FAULT;
        else if (startup_done) state_d = RUN;
      end
      RUN: begin
        if (rep_fail) state_d = FAULT;
      end
      FAULT: begin
        if (fault_clear) state_d = STARTUP;
      end
      default: state_d = STARTUP;
    endcase
  end

  always_comb begin
    fault_d   = (state_d == FAULT);
    ready_d   = (state_d == RUN);
    grant_d   = pop ? arb_grant : '0;
    rd_data_d = pop ? mem[rd_ptr_q] : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_word_q   <= '0;
      prev_valid_q  <= 1'b0;
      rep_cnt_q     <= '0;
      startup_cnt_q <= '0;
    end else if (state_q == FAULT) begin
      if (fault_clear) begin
        prev_valid_q  <= 1'b0;
        rep_cnt_q     <= '0;
        startup_cnt_q <= '0;
      end
    end else if (word_ok) begin
      prev_word_q  <= entropy_word;
      prev_valid_q <= 1'b1;
      rep_cnt_q    <= rep_next;
      if (pass && (state_q == STARTUP)) begin
        startup_cnt_q <= startup_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (enter_fault) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= entropy_word;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_q    <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      fault_q    <= 1'b0;
      ready_q    <= 1'b0;
      drop_q     <= '0;
    end else begin
      grant_q    <= grant_d;
      rd_valid_q <= pop;
      rd_data_q  <= rd_data_d;
      fault_q    <= fault_d;
      ready_q    <= ready_d;
      if (drop && (drop_q != 8'hFF)) begin
        drop_q <= drop_q + 8'd1;
      end
    end
  end

  assign grant      = grant_q;
  assign rd_valid   = rd_valid_q;
  assign rd_data    = rd_data_q;
  assign fault      = fault_q;
  assign ready      = ready_q;
  assign fifo_level = count_q;
  assign drop_count = drop_q;

endmodule
